// File: rtl/cr_huf_comp_ph_mp_pkg.sv
// Shared parameters, record types and helpers for the predetermined-Huffman table store.
package cr_huf_comp_ph_mp_pkg;

  localparam int NUM_RD_PORTS_DEF = 4;
  localparam int NUM_TABLES_DEF   = 10;
  localparam int ENTRIES_DEF      = 22;
  localparam int DATA_W_DEF       = 60;
  localparam int ERR_CNT_W        = 16;

  localparam int TBL_W_DEF = $clog2(NUM_TABLES_DEF);
  localparam int ENT_W_DEF = $clog2(ENTRIES_DEF);

  typedef struct packed {
    logic [TBL_W_DEF-1:0]  tbl_id;
    logic [ENT_W_DEF-1:0]  addr;
    logic [DATA_W_DEF-1:0] data;
  } s_ph_mp_wr;

  typedef struct packed {
    logic                  err;
    logic [DATA_W_DEF-1:0] data;
  } s_ph_mp_rsp;

  function automatic logic [ERR_CNT_W-1:0] errCntSatAdd(input logic [ERR_CNT_W-1:0] a,
                                                        input logic [ERR_CNT_W-1:0] b);
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : sum[ERR_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/cr_huf_comp_ph_mp_if.sv
// Bundle between the predet-table SM / HW engines and the table store.
interface cr_huf_comp_ph_mp_if
  import cr_huf_comp_ph_mp_pkg::*;
#(
  parameter int NUM_RD_PORTS = NUM_RD_PORTS_DEF,
  parameter int NUM_TABLES   = NUM_TABLES_DEF,
  parameter int ENTRIES      = ENTRIES_DEF,
  parameter int DATA_W       = DATA_W_DEF
);
  localparam int TBL_W = $clog2(NUM_TABLES);
  localparam int ENT_W = $clog2(ENTRIES);

  logic                             wr_val;
  logic [TBL_W-1:0]                 wr_tbl_id;
  logic [ENT_W-1:0]                 wr_addr;
  logic [DATA_W-1:0]                wr_data;
  logic [NUM_RD_PORTS-1:0]          rd_req;
  logic [NUM_RD_PORTS*TBL_W-1:0]    rd_tbl_id;
  logic [NUM_RD_PORTS*ENT_W-1:0]    rd_addr;
  logic [NUM_RD_PORTS-1:0]          rd_rdy;
  logic [NUM_RD_PORTS-1:0]          rsp_val;
  logic [NUM_RD_PORTS*DATA_W-1:0]   rsp_data;
  logic [NUM_RD_PORTS-1:0]          rsp_err;
  logic [NUM_TABLES-1:0]            tbl_vld;
  logic [ERR_CNT_W-1:0]             err_cnt;

  modport master (
    output wr_val, wr_tbl_id, wr_addr, wr_data, rd_req, rd_tbl_id, rd_addr,
    input  rd_rdy, rsp_val, rsp_data, rsp_err, tbl_vld, err_cnt
  );

  modport slave (
    input  wr_val, wr_tbl_id, wr_addr, wr_data, rd_req, rd_tbl_id, rd_addr,
    output rd_rdy, rsp_val, rsp_data, rsp_err, tbl_vld, err_cnt
  );

endinterface

// File: rtl/cr_huf_comp_ph_mp_bank.sv
// One replicated 1R1W table bank; registered read, contents are not reset.
module cr_huf_comp_ph_mp_bank
  import cr_huf_comp_ph_mp_pkg::*;
#(
  parameter int DEPTH  = NUM_TABLES_DEF * ENTRIES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PA_W   = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [PA_W-1:0]   wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              re_i,
  input  logic [PA_W-1:0]   ra_i,
  output logic [DATA_W-1:0] rd_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdData_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    if (re_i) rdData_q <= mem_q[ra_i];
  end

  assign rd_o = rdData_q;

endmodule

// File: rtl/cr_huf_comp_ph_mp.sv
// Predetermined-Huffman table store: one SM write port, NUM_RD_PORTS read ports, each with
// its own bank copy, per-table valid tracking, collision stall and a saturating error counter.
module cr_huf_comp_ph_mp
  import cr_huf_comp_ph_mp_pkg::*;
#(
  parameter int NUM_RD_PORTS = NUM_RD_PORTS_DEF,
  parameter int NUM_TABLES   = NUM_TABLES_DEF,
  parameter int ENTRIES      = ENTRIES_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input logic                clk,
  input logic                rst,
  cr_huf_comp_ph_mp_if.slave ph_if
);

  localparam int TBL_W = $clog2(NUM_TABLES);
  localparam int ENT_W = $clog2(ENTRIES);
  localparam int DEPTH = NUM_TABLES * ENTRIES;
  localparam int PA_W  = $clog2(DEPTH);
  localparam int INC_W = $clog2(NUM_RD_PORTS + 1);

  localparam logic [TBL_W:0]   NUM_TABLES_C = (TBL_W+1)'(NUM_TABLES);
  localparam logic [ENT_W:0]   ENTRIES_C    = (ENT_W+1)'(ENTRIES);
  localparam logic [ENT_W-1:0] LAST_ENT     = ENT_W'(ENTRIES - 1);
  localparam logic [PA_W-1:0]  ENTRIES_PA   = PA_W'(ENTRIES);

  function automatic logic tblOk(input logic [TBL_W-1:0] t);
    return {1'b0, t} < NUM_TABLES_C;
  endfunction

  function automatic logic entOk(input logic [ENT_W-1:0] a);
    return {1'b0, a} < ENTRIES_C;
  endfunction

  function automatic logic [PA_W-1:0] physAddr(input logic [TBL_W-1:0] t,
                                               input logic [ENT_W-1:0] a);
    return PA_W'(t) * ENTRIES_PA + PA_W'(a);
  endfunction

  logic                           wrOk;
  logic [PA_W-1:0]                wrPa;
  logic [NUM_TABLES-1:0]          tblVld_q, tblVld_d;
  logic [2**TBL_W-1:0]            tblVldPad;
  logic [NUM_RD_PORTS-1:0]        rdRdy;
  logic [NUM_RD_PORTS-1:0]        rspVal, rspErr;
  logic [NUM_RD_PORTS*DATA_W-1:0] rspData;
  logic [INC_W-1:0]               errInc;
  logic [ERR_CNT_W-1:0]           errCnt_q, errCnt_d;

  always_comb begin
    wrOk = ph_if.wr_val && tblOk(ph_if.wr_tbl_id) && entOk(ph_if.wr_addr);
    wrPa = physAddr(ph_if.wr_tbl_id, ph_if.wr_addr);
  end

  // Set is applied after clear so a single-entry table write leaves it valid.
  always_comb begin
    tblVld_d = tblVld_q;
    for (int t = 0; t < NUM_TABLES; t++) begin
      if (wrOk && (ph_if.wr_tbl_id == TBL_W'(t))) begin
        if (ph_if.wr_addr == '0)      tblVld_d[t] = 1'b0;
        if (ph_if.wr_addr == LAST_ENT) tblVld_d[t] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tblVld_q <= '0;
    else     tblVld_q <= tblVld_d;
  end

  assign tblVldPad = (2**TBL_W)'(tblVld_q);

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : gen_port
    logic [TBL_W-1:0]  rdTbl;
    logic [ENT_W-1:0]  rdAddr;
    logic              accept;
    logic              s1Vld_q, s2Vld_q, s2Err_q;
    logic [TBL_W-1:0]  s1Tbl_q;
    logic [ENT_W-1:0]  s1Addr_q;
    logic              s1Err, bankRe;
    logic [PA_W-1:0]   bankRa;
    logic [DATA_W-1:0] bankData;
    logic              rspVal_q, rspErr_q;
    logic [DATA_W-1:0] rspData_q;

    assign rdTbl    = ph_if.rd_tbl_id[p*TBL_W +: TBL_W];
    assign rdAddr   = ph_if.rd_addr[p*ENT_W +: ENT_W];
    assign rdRdy[p] = !(ph_if.wr_val && (ph_if.wr_tbl_id == rdTbl));
    assign accept   = ph_if.rd_req[p] && rdRdy[p];

    // Erroneous requests never touch the bank; they still flow down the pipe as err slots.
    assign s1Err  = !tblOk(s1Tbl_q) || !entOk(s1Addr_q) || !tblVldPad[s1Tbl_q];
    assign bankRe = s1Vld_q && !s1Err;
    assign bankRa = physAddr(s1Tbl_q, s1Addr_q);

    cr_huf_comp_ph_mp_bank #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .PA_W  (PA_W)
    ) u_bank (
      .clk_i(clk),
      .we_i (wrOk),
      .wa_i (wrPa),
      .wd_i (ph_if.wr_data),
      .re_i (bankRe),
      .ra_i (bankRa),
      .rd_o (bankData)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1Vld_q   <= 1'b0;
        s1Tbl_q   <= '0;
        s1Addr_q  <= '0;
        s2Vld_q   <= 1'b0;
        s2Err_q   <= 1'b0;
        rspVal_q  <= 1'b0;
        rspErr_q  <= 1'b0;
        rspData_q <= '0;
      end else begin
        s1Vld_q <= accept;
        if (accept) begin
          s1Tbl_q  <= rdTbl;
          s1Addr_q <= rdAddr;
        end
        s2Vld_q <= s1Vld_q;
        if (s1Vld_q) s2Err_q <= s1Err;
        rspVal_q <= s2Vld_q;
        if (s2Vld_q) begin
          rspErr_q  <= s2Err_q;
          rspData_q <= s2Err_q ? '0 : bankData;
        end
      end
    end

    assign rspVal[p]                  = rspVal_q;
    assign rspErr[p]                  = rspErr_q;
    assign rspData[p*DATA_W +: DATA_W] = rspData_q;
  end

  always_comb begin
    errInc = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      errInc = errInc + INC_W'(rspVal[p] & rspErr[p]);
    end
    errCnt_d = errCntSatAdd(errCnt_q, ERR_CNT_W'(errInc));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) errCnt_q <= '0;
    else     errCnt_q <= errCnt_d;
  end

  assign ph_if.rd_rdy   = rdRdy;
  assign ph_if.rsp_val  = rspVal;
  assign ph_if.rsp_err  = rspErr;
  assign ph_if.rsp_data = rspData;
  assign ph_if.tbl_vld  = tblVld_q;
  assign ph_if.err_cnt  = errCnt_q;

endmodule

// File: tb/tb_cr_huf_comp_ph_mp.sv
// Scoreboard bench for the table store: stimulus pushes model responses, a monitor pops them.
module tb_cr_huf_comp_ph_mp;
  import cr_huf_comp_ph_mp_pkg::*;

  localparam int NP = 4;
  localparam int NT = 10;
  localparam int NE = 22;
  localparam int DW = 60;
  localparam int TW = $clog2(NT);
  localparam int EW = $clog2(NE);

  typedef struct {
    s_ph_mp_rsp rsp;
    int         cyc;
  } expEntryT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cycle = 0;
  int   assertCount = 0;
  int   failCount = 0;

  logic [DW-1:0] modelMem [16][32];
  logic [NT-1:0] modelVld = '0;
  int unsigned   modelErr = 0;
  expEntryT      expQ [NP][$];
  logic [DW-1:0] lastData [NP];
  logic          lastErr [NP];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  cr_huf_comp_ph_mp_if #(.NUM_RD_PORTS(NP), .NUM_TABLES(NT), .ENTRIES(NE), .DATA_W(DW)) phIf ();

  cr_huf_comp_ph_mp #(
    .NUM_RD_PORTS(NP),
    .NUM_TABLES  (NT),
    .ENTRIES     (NE),
    .DATA_W      (DW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ph_if(phIf.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s @cycle %0d: got %0h required %0h", name, cycle, act, exp);
    end
  endtask

  // Reference answer straight from the table rules: out of range or unloaded table is an error.
  function automatic s_ph_mp_rsp refRead(input int t, input int a);
    s_ph_mp_rsp r;
    if (t >= NT || a >= NE || !modelVld[t]) begin
      r.err  = 1'b1;
      r.data = '0;
    end else begin
      r.err  = 1'b0;
      r.data = modelMem[t][a];
    end
    return r;
  endfunction

  function automatic logic [NP*TW-1:0] packT(input int t0, input int t1, input int t2, input int t3);
    return {TW'(t3), TW'(t2), TW'(t1), TW'(t0)};
  endfunction

  function automatic logic [NP*EW-1:0] packA(input int a0, input int a1, input int a2, input int a3);
    return {EW'(a3), EW'(a2), EW'(a1), EW'(a0)};
  endfunction

  task automatic applyStimulus(input bit wv, input s_ph_mp_wr wr, input logic [NP-1:0] req,
                               input logic [NP*TW-1:0] tbls, input logic [NP*EW-1:0] addrs);
    bit       expRdy;
    expEntryT e;
    @(posedge clk);
    #1;
    phIf.wr_val    = wv;
    phIf.wr_tbl_id = wr.tbl_id;
    phIf.wr_addr   = wr.addr;
    phIf.wr_data   = wr.data;
    phIf.rd_req    = req;
    phIf.rd_tbl_id = tbls;
    phIf.rd_addr   = addrs;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      expRdy = !(wv && (wr.tbl_id == tbls[p*TW +: TW]));
      check("rdRdy", 64'(phIf.rd_rdy[p]), 64'(expRdy));
      if (req[p] && expRdy) begin
        e.rsp = refRead(int'(tbls[p*TW +: TW]), int'(addrs[p*EW +: EW]));
        e.cyc = cycle;
        expQ[p].push_back(e);
      end
    end
    if (wv && wr.tbl_id < NT && wr.addr < NE) begin
      modelMem[wr.tbl_id][wr.addr] = wr.data;
      if (wr.addr == 0)      modelVld[wr.tbl_id] = 1'b0;
      if (wr.addr == NE - 1) modelVld[wr.tbl_id] = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    s_ph_mp_wr w;
    w = '0;
    repeat (n) applyStimulus(1'b0, w, '0, '0, '0);
  endtask

  task automatic resetDut(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    phIf.wr_val = 1'b0;
    phIf.rd_req = '0;
    for (int p = 0; p < NP; p++) begin
      expQ[p].delete();
      lastData[p] = '0;
      lastErr[p]  = 1'b0;
    end
    modelVld = '0;
    modelErr = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int randTbl();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
  endfunction

  function automatic int randAddr();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(22, 31)) : int'($urandom_range(0, 21));
  endfunction

  task automatic randomCycle(input bit wv, input s_ph_mp_wr wr);
    logic [NP-1:0]    req;
    logic [NP*TW-1:0] tbls;
    logic [NP*EW-1:0] addrs;
    req = NP'($urandom);
    for (int p = 0; p < NP; p++) begin
      tbls[p*TW +: TW]  = ($urandom_range(0, 2) == 0) ? wr.tbl_id : TW'(randTbl());
      addrs[p*EW +: EW] = EW'(randAddr());
    end
    applyStimulus(wv, wr, req, tbls, addrs);
  endtask

  task automatic checkOutput();
    int       nErr;
    expEntryT e;
    if (rst) begin
      check("rstRspVal", 64'(phIf.rsp_val), 64'(0));
      check("rstTblVld", 64'(phIf.tbl_vld), 64'(0));
      check("rstErrCnt", 64'(phIf.err_cnt), 64'(0));
      return;
    end
    check("tblVld", 64'(phIf.tbl_vld), 64'(modelVld));
    check("errCnt", 64'(phIf.err_cnt), 64'(modelErr));
    nErr = 0;
    for (int p = 0; p < NP; p++) begin
      while (expQ[p].size() > 0 && expQ[p][0].cyc + 3 < cycle) begin
        e = expQ[p].pop_front();
        assertCount++;
        failCount++;
        $display("[TB] FAIL rspMissing port %0d: no rsp_val for read accepted at cycle %0d, required at %0d",
                 p, e.cyc, e.cyc + 3);
      end
      if (phIf.rsp_val[p]) begin
        assertCount++;
        if (expQ[p].size() == 0) begin
          failCount++;
          $display("[TB] FAIL rspSpurious port %0d @cycle %0d: rsp_val 1, required 0", p, cycle);
        end else begin
          e = expQ[p].pop_front();
          check("rspLatency", 64'(cycle), 64'(e.cyc + 3));
          check("rspErr", 64'(phIf.rsp_err[p]), 64'(e.rsp.err));
          check("rspData", 64'(phIf.rsp_data[p*DW +: DW]), 64'(e.rsp.data));
          lastData[p] = e.rsp.data;
          lastErr[p]  = e.rsp.err;
          if (e.rsp.err) nErr++;
        end
      end else begin
        check("rspErrHold", 64'(phIf.rsp_err[p]), 64'(lastErr[p]));
        check("rspDataHold", 64'(phIf.rsp_data[p*DW +: DW]), 64'(lastData[p]));
      end
    end
    modelErr = (modelErr + nErr > 32'hFFFF) ? 32'hFFFF : modelErr + nErr;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      checkOutput();
    end
  end

  initial begin
    s_ph_mp_wr w;
    s_ph_mp_wr none;
    none = '0;
    phIf.wr_val    = 1'b0;
    phIf.wr_tbl_id = '0;
    phIf.wr_addr   = '0;
    phIf.wr_data   = '0;
    phIf.rd_req    = '0;
    phIf.rd_tbl_id = '0;
    phIf.rd_addr   = '0;
    for (int p = 0; p < NP; p++) begin
      lastData[p] = '0;
      lastErr[p]  = 1'b0;
    end

    resetDut(3);

    for (int a = 0; a < NE; a++) begin
      w.tbl_id = TW'(3);
      w.addr   = EW'(a);
      w.data   = DW'(a + 'h100);
      applyStimulus(1'b1, w, '0, '0, '0);
    end
    idle(2);
    check("tblVldOnly3", 64'(phIf.tbl_vld), 64'h008);

    applyStimulus(1'b0, none, 4'b0001, packT(3, 0, 0, 0), packA(5, 0, 0, 0));
    idle(4);

    repeat (20) applyStimulus(1'b0, none, 4'b1111, packT(3, 3, 3, 3), packA(0, 1, 2, 3));
    idle(4);

    applyStimulus(1'b0, none, 4'b0111, packT(4, 3, 12, 0), packA(0, 22, 0, 0));
    idle(5);
    check("errCntThree", 64'(phIf.err_cnt), 64'd3);

    // Port 1 collides with the write and must stall; port 2 is on another table.
    w.tbl_id = TW'(3);
    w.addr   = EW'(7);
    w.data   = DW'('hABC);
    applyStimulus(1'b1, w, 4'b0110, packT(0, 3, 5, 0), packA(0, 7, 0, 0));
    applyStimulus(1'b0, none, 4'b0010, packT(0, 3, 0, 0), packA(0, 7, 0, 0));
    idle(4);
    w.addr = '0;
    w.data = DW'('h55);
    applyStimulus(1'b1, w, '0, '0, '0);
    idle(2);
    check("tblVld3Cleared", 64'(phIf.tbl_vld[3]), 64'd0);

    for (int t = 0; t < NT; t++) begin
      for (int a = 0; a < NE; a++) begin
        w.tbl_id = TW'(t);
        w.addr   = EW'(a);
        w.data   = DW'({$urandom, $urandom});
        randomCycle(1'b1, w);
      end
    end

    for (int i = 0; i < 400; i++) begin
      w.tbl_id = TW'(randTbl());
      w.addr   = EW'(randAddr());
      w.data   = DW'({$urandom, $urandom});
      randomCycle($urandom_range(0, 2) == 0, w);
    end

    applyStimulus(1'b0, none, 4'b0111, packT(3, 5, 12, 0), packA(1, 2, 3, 0));
    resetDut(2);
    idle(6);
    check("postRstTblVld", 64'(phIf.tbl_vld), 64'd0);
    check("postRstErrCnt", 64'(phIf.err_cnt), 64'd0);

    repeat (16383) applyStimulus(1'b0, none, 4'b1111, packT(12, 12, 12, 12), '0);
    applyStimulus(1'b0, none, 4'b0011, packT(12, 12, 0, 0), '0);
    idle(5);
    check("errCntFFFE", 64'(phIf.err_cnt), 64'hFFFE);
    applyStimulus(1'b0, none, 4'b0111, packT(12, 12, 12, 0), '0);
    idle(5);
    check("errCntSat", 64'(phIf.err_cnt), 64'hFFFF);
    applyStimulus(1'b0, none, 4'b0001, packT(12, 0, 0, 0), '0);
    idle(5);
    check("errCntHold", 64'(phIf.err_cnt), 64'hFFFF);

    idle(2);
    for (int p = 0; p < NP; p++) check("queueDrained", 64'(expQ[p].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
